// File: rtl/laser310_ram64k_pkg.sv
// Shared constants for the Laser 310 64 KiB RAM expansion glue.
// Holds the bank port decode, the reset bank value and the memory region boundaries.
package laser310_ram64k_pkg;

  localparam logic [3:0] BANK_PORT     = 4'b0111;
  localparam logic [1:0] BANK_RESET    = 2'b01;
  localparam logic [4:0] RAM_BASE      = 5'b10111;
  localparam logic [1:0] WINDOW_PREFIX = 2'b11;

  typedef logic [1:0] bank_t;

  // A Z80 I/O write cycle: /IORQ and /WR low, /MREQ and /RD high.
  function automatic logic is_io_write(input logic iorq_n, input logic mreq_n,
                                       input logic wr_n, input logic rd_n);
    return !iorq_n && mreq_n && !wr_n && rd_n;
  endfunction

endpackage

// File: rtl/laser310_bank_reg.sv
// Two-bit bank register loaded from the data bus on a decoded I/O write.
// Cleared asynchronously to its reset bank whenever RESET_N is low.
module laser310_bank_reg
  import laser310_ram64k_pkg::*;
#(
  parameter logic [1:0] RESET_VAL = 2'b01
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       load,
  input  logic [1:0] d,
  output logic [1:0] bank
);

  bank_t bank_reg;

  // An I/O write spans several clocks; reloading the same value each edge is benign.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bank_reg <= RESET_VAL;
    end else if (load) begin
      bank_reg <= d;
    end
  end

  assign bank = bank_reg;

endmodule

// File: rtl/laser310_ram64k.sv
// Z80 memory decode for an external 64 KiB SRAM at B800H-FFFFH.
// C000H-FFFFH is a 16 KiB window banked through I/O port 7xH; B800H-BFFFH is fixed.
module laser310_ram64k #(
  parameter logic [3:0] BANK_PORT  = laser310_ram64k_pkg::BANK_PORT,
  parameter logic [1:0] BANK_RESET = laser310_ram64k_pkg::BANK_RESET
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [4:0] Addr,
  input  logic [3:0] AddrIO,
  input  logic       WR_N,
  input  logic       RD_N,
  input  logic       MREQ_N,
  input  logic       IORQ_N,
  input  logic [1:0] D1D0,
  output logic [1:0] RAM_A1514,
  output logic       RAM_CS_N,
  output logic       RAM_OE_N,
  output logic       RAM_WE_N,
  output logic       led1,
  output logic       led2
);
  import laser310_ram64k_pkg::*;

  bank_t bank;
  logic  bank_load;
  logic  mem_cycle;
  logic  ram_hit;

  assign bank_load = is_io_write(IORQ_N, MREQ_N, WR_N, RD_N) && (AddrIO == BANK_PORT);

  laser310_bank_reg #(
    .RESET_VAL(BANK_RESET)
  ) u_bank_reg (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .load   (bank_load),
    .d      (D1D0),
    .bank   (bank)
  );

  // mem_cycle gates the address compare first so an undriven Addr cannot reach CS_N.
  assign mem_cycle = !MREQ_N && IORQ_N && (RD_N ^ WR_N);
  assign ram_hit   = mem_cycle && (Addr >= RAM_BASE);

  assign RAM_CS_N = !ram_hit;
  assign RAM_OE_N = !(ram_hit && !RD_N);
  assign RAM_WE_N = !(ram_hit && !WR_N);

  // B800H-BFFFH always lands on physical 3800H-3FFFH; only the top 16 KiB is banked.
  assign RAM_A1514 = (Addr[4:3] == WINDOW_PREFIX) ? bank : 2'b00;

  assign led1 = bank[0];
  assign led2 = bank[1];

endmodule

// File: tb/tb_laser310_ram64k.sv
// Scoreboard bench for laser310_ram64k: stimulus pushes expected responses computed
// from a 16-bit address map model; a negedge monitor pops and compares them.
module tb_laser310_ram64k;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [4:0] Addr = 5'b00000;
  logic [3:0] AddrIO = 4'h0;
  logic       WR_N = 1'b1;
  logic       RD_N = 1'b1;
  logic       MREQ_N = 1'b1;
  logic       IORQ_N = 1'b1;
  logic [1:0] D1D0 = 2'b00;
  logic [1:0] RAM_A1514;
  logic       RAM_CS_N;
  logic       RAM_OE_N;
  logic       RAM_WE_N;
  logic       led1;
  logic       led2;

  laser310_ram64k dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .Addr     (Addr),
    .AddrIO   (AddrIO),
    .WR_N     (WR_N),
    .RD_N     (RD_N),
    .MREQ_N   (MREQ_N),
    .IORQ_N   (IORQ_N),
    .D1D0     (D1D0),
    .RAM_A1514(RAM_A1514),
    .RAM_CS_N (RAM_CS_N),
    .RAM_OE_N (RAM_OE_N),
    .RAM_WE_N (RAM_WE_N),
    .led1     (led1),
    .led2     (led2)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         id;
    logic       cs_n;
    logic       oe_n;
    logic       we_n;
    logic [1:0] a1514;
    logic [1:0] leds;
    bit         chk_a;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   txn = 0;
  logic [1:0] m_bank = 2'b01;

  task automatic chk(input int id, input string name, input logic [1:0] act, input logic [1:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL txn %0d %s: got %b expected %b", id, name, act, req);
  endtask

  // Monitor: outputs are combinational, so each transaction presents at the next negedge.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.id, "cs_n", {1'b0, RAM_CS_N}, {1'b0, e.cs_n});
      chk(e.id, "oe_n", {1'b0, RAM_OE_N}, {1'b0, e.oe_n});
      chk(e.id, "we_n", {1'b0, RAM_WE_N}, {1'b0, e.we_n});
      chk(e.id, "leds", {led2, led1}, e.leds);
      if (e.chk_a) chk(e.id, "a1514", RAM_A1514, e.a1514);
      $display("txn %0d addr=%b io=%b wr=%b rd=%b mreq=%b iorq=%b d=%b rst=%b -> cs=%b oe=%b we=%b a=%b leds=%b%b",
               e.id, Addr, AddrIO, WR_N, RD_N, MREQ_N, IORQ_N, D1D0, RESET_N,
               RAM_CS_N, RAM_OE_N, RAM_WE_N, RAM_A1514, led2, led1);
    end
  end

  // Reference model: bank port written on a clock edge when an I/O write targets port 7xH.
  task automatic model_edge();
    if (!RESET_N) m_bank = 2'b01;
    else if (!IORQ_N && MREQ_N && !WR_N && RD_N && AddrIO == 4'h7) m_bank = D1D0;
  endtask

  task automatic push_expect(input bit chk_a);
    exp_t e;
    logic [15:0] a16;
    logic valid, hit;
    a16   = {Addr, 11'b0};
    valid = !MREQ_N && IORQ_N && (RD_N != WR_N);
    hit   = valid && (a16 >= 16'hB800);
    e.id    = txn++;
    e.cs_n  = !hit;
    e.oe_n  = !(hit && !RD_N);
    e.we_n  = !(hit && !WR_N);
    e.a1514 = (a16 >= 16'hC000) ? m_bank : 2'b00;
    e.leds  = RESET_N ? m_bank : 2'b01;
    e.chk_a = chk_a;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [4:0] a, input logic [3:0] io, input logic wr, input logic rd,
                       input logic mreq, input logic iorq, input logic [1:0] d, input bit chk_a);
    @(posedge CLK);
    model_edge();
    #1;
    RESET_N = 1'b1;
    Addr = a; AddrIO = io; WR_N = wr; RD_N = rd; MREQ_N = mreq; IORQ_N = iorq; D1D0 = d;
    push_expect(chk_a);
  endtask

  task automatic pulse_reset();
    @(posedge CLK);
    model_edge();
    #1;
    RESET_N = 1'b0;
    m_bank = 2'b01;
    push_expect(1'b1);
  endtask

  task automatic mem_rd(input logic [4:0] a);
    drive(a, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1);
  endtask

  task automatic io_wr(input logic [3:0] io, input logic [1:0] d);
    repeat (2) drive(5'b00000, io, 1'b0, 1'b1, 1'b1, 1'b0, d, 1'b1);
  endtask

  initial begin
    pulse_reset();
    // Invalid strobe combinations, including an undriven address.
    drive(5'bxxxxx, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0);
    drive(5'bxxxxx, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    drive(5'bxxxxx, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0);
    drive(5'b11111, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1);
    drive(5'b11111, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    drive(5'b11111, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1);
    // Region boundaries.
    drive(5'b10111, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1);
    mem_rd(5'b10111);
    mem_rd(5'b10110);
    mem_rd(5'b11000);
    mem_rd(5'b11111);
    mem_rd(5'b10111);
    // Bank port writes, then a write to a neighbouring port that must be ignored.
    io_wr(4'h7, 2'b00); mem_rd(5'b11010);
    io_wr(4'h7, 2'b10); mem_rd(5'b11101);
    io_wr(4'h7, 2'b11); mem_rd(5'b11000);
    io_wr(4'h6, 2'b00); mem_rd(5'b11110);
    pulse_reset();
    mem_rd(5'b11100);
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        pulse_reset();
      end else begin
        logic [3:0] io;
        io = ($urandom_range(0, 2) != 0) ? 4'h7 : 4'($urandom);
        drive(5'($urandom), io, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              2'($urandom), 1'b1);
      end
    end
    begin
      int budget;
      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge CLK);
        budget--;
      end
      if (exp_q.size() > 0) begin
        checks++;
        $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
      end
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
